// File: rtl/updi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updi_rx_pkg
// Purpose  : Shared types, constants and the character classifier for the
//            UPDI receive-side deframer.
// Contents : updi_rx_state_t  - link state (WAIT_SYNCH / ACTIVE / ERROR)
//            updi_rx_class_t  - per-character classification result
//            UPDI_SYNCH_CHAR, UPDI_BREAK_FRAME, raw character field positions
//            updi_rx_classify - priority classifier for a raw 12-bit character
// Revision : 1.0 - initial release
// ============================================================================
package updi_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNCH = 2'd0,
    ACTIVE     = 2'd1,
    ERROR      = 2'd2
  } updi_rx_state_t;

  typedef enum logic [1:0] {
    CLS_BREAK     = 2'd0,
    CLS_FRAME_ERR = 2'd1,
    CLS_PARITY    = 2'd2,
    CLS_VALID     = 2'd3
  } updi_rx_class_t;

  localparam logic [7:0]  UPDI_SYNCH_CHAR  = 8'h55;
  localparam logic [11:0] UPDI_BREAK_FRAME = 12'h000;

  localparam int START_BIT  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_BIT = 9;
  localparam int STOP_LSB   = 10;
  localparam int STOP_MSB   = 11;

  // BREAK beats framing, framing beats parity: an all-zero character would
  // otherwise look like a stop-bit error.
  function automatic updi_rx_class_t updi_rx_classify(input logic [11:0] f);
    updi_rx_class_t c;
    if (f == UPDI_BREAK_FRAME) begin
      c = CLS_BREAK;
    end else if (f[START_BIT] || (f[STOP_MSB:STOP_LSB] != 2'b11)) begin
      c = CLS_FRAME_ERR;
    end else if (^f[PARITY_BIT:DATA_LSB]) begin
      c = CLS_PARITY;
    end else begin
      c = CLS_VALID;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/updi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : updi_rx_fifo
// Purpose  : Synchronous byte FIFO with flush for the UPDI receive path.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_push/i_push_data - write strobe and byte
//            i_pop         - read strobe (ignored when empty)
//            i_flush       - empty the FIFO; wins over push and pop
//            o_data        - head byte (0 when empty)
//            o_full/o_empty - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module updi_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Masking keeps the head at zero whenever nothing is stored.
  assign o_data = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !rst) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/updi_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : updi_rx_deframer
// Purpose  : UPDI receive character deframer. Classifies raw 12-bit UART
//            characters (BREAK / frame error / parity error / valid), runs
//            the link state machine and buffers data bytes for the datalink.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            frm_valid, frm_data      - character strobe and raw character
//            byte_valid, byte_data, byte_ready - consumer byte stream
//            link_active              - link state is ACTIVE
//            synch_seen, break_det    - one-cycle event pulses
//            err_parity, err_frame, err_overrun - one-cycle error pulses
//            err_cnt                  - saturating error count
// Config   : UPDI_RX_ERRCNT_EN - when defined, err_cnt counts error pulses
//            and saturates; when undefined err_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module updi_rx_deframer
  import updi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frm_valid,
  input  logic [11:0]         frm_data,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  input  logic                byte_ready,
  output logic                link_active,
  output logic                synch_seen,
  output logic                break_det,
  output logic                err_parity,
  output logic                err_frame,
  output logic                err_overrun,
  output logic [ERRCNT_W-1:0] err_cnt
);

  updi_rx_state_t r_state;
  updi_rx_state_t w_state_next;
  updi_rx_class_t w_class;

  logic       w_push;
  logic       w_pop;
  logic       w_flush;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_rx_byte;

  logic w_synch;
  logic w_break;
  logic w_parity;
  logic w_frame;
  logic w_overrun;

  assign w_class   = updi_rx_classify(frm_data);
  assign w_rx_byte = frm_data[DATA_MSB:DATA_LSB];
  assign w_pop     = !w_empty && byte_ready;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_synch      = 1'b0;
    w_break      = 1'b0;
    w_parity     = 1'b0;
    w_frame      = 1'b0;
    w_overrun    = 1'b0;
    if (frm_valid) begin
      if (w_class == CLS_BREAK) begin
        w_flush      = 1'b1;
        w_break      = 1'b1;
        w_state_next = WAIT_SYNCH;
      end else begin
        case (r_state)
          WAIT_SYNCH: begin
            if (w_class == CLS_VALID && w_rx_byte == UPDI_SYNCH_CHAR) begin
              w_synch      = 1'b1;
              w_state_next = ACTIVE;
            end
          end
          ACTIVE: begin
            case (w_class)
              CLS_VALID: begin
                if (w_full && !w_pop) begin
                  w_overrun    = 1'b1;
                  w_flush      = 1'b1;
                  w_state_next = ERROR;
                end else begin
                  w_push = 1'b1;
                end
              end
              CLS_PARITY: begin
                w_parity     = 1'b1;
                w_flush      = 1'b1;
                w_state_next = ERROR;
              end
              CLS_FRAME_ERR: begin
                w_frame      = 1'b1;
                w_flush      = 1'b1;
                w_state_next = ERROR;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_SYNCH;
      synch_seen  <= 1'b0;
      break_det   <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      synch_seen  <= w_synch;
      break_det   <= w_break;
      err_parity  <= w_parity;
      err_frame   <= w_frame;
      err_overrun <= w_overrun;
    end
  end

  assign link_active = (r_state == ACTIVE);

`ifdef UPDI_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;
  logic                w_err_evt;

  assign w_err_evt = w_parity || w_frame || w_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_evt && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

  updi_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_rx_byte),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_data      (byte_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign byte_valid = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_updi_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_updi_rx_deframer
// Purpose  : Directed self-checking bench for updi_rx_deframer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updi_rx_deframer;

  localparam int FIFO_DEPTH = 4;
  localparam int ERRCNT_W   = 8;
`ifdef UPDI_RX_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                frm_valid;
  logic [11:0]         frm_data;
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                byte_ready;
  logic                link_active;
  logic                synch_seen;
  logic                break_det;
  logic                err_parity;
  logic                err_frame;
  logic                err_overrun;
  logic [ERRCNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // {link_active, synch_seen, break_det, err_parity, err_frame, err_overrun, byte_valid}
  logic [6:0] w_status;
  assign w_status = {link_active, synch_seen, break_det, err_parity,
                     err_frame, err_overrun, byte_valid};

  always #5 clk = ~clk;

  updi_rx_deframer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ERRCNT_W   (ERRCNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frm_valid   (frm_valid),
    .frm_data    (frm_data),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .link_active (link_active),
    .synch_seen  (synch_seen),
    .break_det   (break_det),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_overrun (err_overrun),
    .err_cnt     (err_cnt)
  );

  function automatic logic [11:0] mkframe(input logic [7:0] d);
    return {2'b11, ^d, d, 1'b0};
  endfunction

  function automatic logic [ERRCNT_W-1:0] exp_cnt(input int n);
    if (!CNT_EN) return '0;
    if (n >= (1 << ERRCNT_W) - 1) return '1;
    return ERRCNT_W'(n);
  endfunction

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic strobe(input logic [11:0] f);
    frm_data  = f;
    frm_valid = 1'b1;
    @(negedge clk);
    frm_valid = 1'b0;
    frm_data  = 12'h000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; frm_valid = 1'b0; frm_data = 12'h000; byte_ready = 1'b0;
    idle(3);
    checks++;
    if (w_status !== 7'b0000000 || byte_data !== 8'h00 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset: status=%b data=%h cnt=%0d required status=0000000 data=00 cnt=0",
               w_status, byte_data, err_cnt);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_synch();
    strobe(mkframe(8'h3C));
    checks++;
    if (w_status !== 7'b0000000) begin
      errors++; $display("FAIL wait_valid_nonsynch: status=%b required 0000000", w_status);
    end
    idle(12);
    strobe(12'h4AA);
    checks++;
    if (w_status !== 7'b0000000) begin
      errors++; $display("FAIL wait_frame_err_silent: status=%b required 0000000", w_status);
    end
    idle(12);
    strobe(12'hCAA);
    checks++;
    if (w_status !== 7'b1100000) begin
      errors++; $display("FAIL synch: status=%b required 1100000", w_status);
    end
    idle(1);
    checks++;
    if (w_status !== 7'b1000000) begin
      errors++; $display("FAIL synch_pulse_end: status=%b required 1000000", w_status);
    end
    idle(11);
  endtask

  task automatic test_data();
    byte_ready = 1'b1;
    strobe(12'hE02);
    checks++;
    if (w_status !== 7'b1000001 || byte_data !== 8'h01) begin
      errors++; $display("FAIL data_01: status=%b data=%h required 1000001/01", w_status, byte_data);
    end
    idle(1);
    checks++;
    if (w_status !== 7'b1000000) begin
      errors++; $display("FAIL data_01_popped: status=%b required 1000000", w_status);
    end
    idle(11);
    strobe(12'hD4A);
    checks++;
    if (w_status !== 7'b1000001 || byte_data !== 8'hA5) begin
      errors++; $display("FAIL data_A5: status=%b data=%h required 1000001/a5", w_status, byte_data);
    end
    idle(12);
  endtask

  task automatic test_parity();
    byte_ready = 1'b0;
    strobe(mkframe(8'h77));
    checks++;
    if (w_status !== 7'b1000001 || byte_data !== 8'h77) begin
      errors++; $display("FAIL parity_prefill: status=%b data=%h required 1000001/77", w_status, byte_data);
    end
    idle(12);
    // Pop coincides with the flush caused by the parity error.
    byte_ready = 1'b1;
    strobe(12'hC02);
    byte_ready = 1'b0;
    checks++;
    if (w_status !== 7'b0001000 || byte_data !== 8'h00) begin
      errors++; $display("FAIL parity_err: status=%b data=%h required 0001000/00", w_status, byte_data);
    end
    idle(12);
    strobe(12'hCAA);
    checks++;
    if (w_status !== 7'b0000000) begin
      errors++; $display("FAIL error_ignores_synch: status=%b required 0000000", w_status);
    end
    idle(12);
    strobe(12'h000);
    checks++;
    if (w_status !== 7'b0010000) begin
      errors++; $display("FAIL break: status=%b required 0010000", w_status);
    end
    idle(12);
    strobe(12'hCAA);
    checks++;
    if (w_status !== 7'b1100000) begin
      errors++; $display("FAIL resynch: status=%b required 1100000", w_status);
    end
    idle(12);
  endtask

  task automatic test_overrun();
    byte_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      strobe(mkframe(8'h10 + 8'(i)));
      idle(12);
    end
    checks++;
    if (w_status !== 7'b1000001 || byte_data !== 8'h10) begin
      errors++; $display("FAIL fifo_full_head: status=%b data=%h required 1000001/10", w_status, byte_data);
    end
    strobe(mkframe(8'h20));
    checks++;
    if (w_status !== 7'b0000010) begin
      errors++; $display("FAIL overrun: status=%b required 0000010", w_status);
    end
    idle(12);
    strobe(12'h000); idle(12);
    strobe(12'hCAA); idle(12);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      strobe(mkframe(8'h30 + 8'(i)));
      idle(12);
    end
    byte_ready = 1'b1;
    strobe(mkframe(8'h34));
    checks++;
    if (w_status !== 7'b1000001 || byte_data !== 8'h31) begin
      errors++; $display("FAIL full_push_with_pop: status=%b data=%h required 1000001/31", w_status, byte_data);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (byte_valid !== 1'b1 || byte_data !== 8'h30 + 8'(k)) begin
        errors++; $display("FAIL drain_%0d: valid=%b data=%h required 1/%h", k, byte_valid, byte_data, 8'h30 + 8'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (w_status !== 7'b1000000) begin
      errors++; $display("FAIL drain_empty: status=%b required 1000000", w_status);
    end
    byte_ready = 1'b0;
    idle(12);
  endtask

  task automatic test_errcnt();
    rst = 1'b1; idle(2); rst = 1'b0; idle(2);
    strobe(12'hCAA); idle(12);
    strobe(12'h4AA);
    checks++;
    if (w_status !== 7'b0000100 || err_cnt !== exp_cnt(1)) begin
      errors++; $display("FAIL frame_stop: status=%b cnt=%0d required 0000100/%0d", w_status, err_cnt, exp_cnt(1));
    end
    idle(12);
    strobe(12'h000); idle(12);
    strobe(12'hCAA); idle(12);
    strobe(12'hCAB);
    checks++;
    if (w_status !== 7'b0000100 || err_cnt !== exp_cnt(2)) begin
      errors++; $display("FAIL frame_start: status=%b cnt=%0d required 0000100/%0d", w_status, err_cnt, exp_cnt(2));
    end
    idle(12);
    for (int i = 0; i < (1 << ERRCNT_W) + 1; i++) begin
      strobe(12'h000); idle(12);
      strobe(12'hCAA); idle(12);
      strobe(12'hC02); idle(12);
    end
    checks++;
    if (err_cnt !== exp_cnt((1 << ERRCNT_W) + 3)) begin
      errors++; $display("FAIL errcnt_saturate: cnt=%0d required %0d", err_cnt, exp_cnt((1 << ERRCNT_W) + 3));
    end
  endtask

  task automatic test_rst_mid();
    byte_ready = 1'b0;
    strobe(12'h000); idle(12);
    strobe(12'hCAA); idle(12);
    for (int i = 0; i < 3; i++) begin
      strobe(mkframe(8'h40 + 8'(i)));
      idle(12);
    end
    checks++;
    if (w_status !== 7'b1000001 || byte_data !== 8'h40) begin
      errors++; $display("FAIL rst_prefill: status=%b data=%h required 1000001/40", w_status, byte_data);
    end
    // BREAK presented at the reset edge must not pulse break_det.
    rst = 1'b1;
    strobe(12'h000);
    checks++;
    if (w_status !== 7'b0000000 || byte_data !== 8'h00 || err_cnt !== '0) begin
      errors++; $display("FAIL rst_mid: status=%b data=%h cnt=%0d required 0000000/00/0", w_status, byte_data, err_cnt);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (w_status !== 7'b0000000) begin
      errors++; $display("FAIL rst_release: status=%b required 0000000", w_status);
    end
  endtask

  initial begin
    rst = 1'b1; frm_valid = 1'b0; frm_data = 12'h000; byte_ready = 1'b0;
    test_reset();
    test_synch();
    test_data();
    test_parity();
    test_overrun();
    test_errcnt();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updi_rx_deframer.md
# updi_rx_deframer

Receive-side character deframer between the UPDI PHY loader and the datalink layer. Takes raw 12-bit UART characters from the PHY, checks start, parity and stop bits, and detects BREAK and SYNCH. It tracks the UPDI link state (wait-synch / active / error) and buffers validated data bytes in a small FIFO for the datalink consumer.

## Interface
Parameters:
- FIFO_DEPTH, 4: byte FIFO depth; power of two, at least 2.
- ERRCNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  Rising-edge clock; single clock domain.
- rst  in  1  Synchronous, active-high reset.
- frm_valid  in  1  One-cycle strobe from the PHY; frm_data holds a complete character.
- frm_data  in  12  Raw character. bit0 = start, bits[8:1] = data (LSB first), bit9 = even parity, bits[11:10] = stop.
- byte_valid  out  1  FIFO non-empty; byte_data is valid.
- byte_data  out  8  FIFO head byte.
- byte_ready  in  1  Consumer pop; a pop occurs when byte_valid && byte_ready.
- link_active  out  1  High while the state is ACTIVE.
- synch_seen  out  1  One-cycle pulse when SYNCH (0x55) is accepted in WAIT_SYNCH.
- break_det  out  1  One-cycle pulse when a BREAK character is received.
- err_parity  out  1  One-cycle pulse on a parity error.
- err_frame  out  1  One-cycle pulse on a start or stop error.
- err_overrun  out  1  One-cycle pulse when a valid byte arrives with the FIFO full.
- err_cnt  out  ERRCNT_W  Saturating count of parity, frame and overrun errors.

## Operation
Each accepted frame is classified with the following priority:
- BREAK: frm_data == 12'h000.
- FRAME error: bit0 = 1, or bits[11:10] != 2'b11.
- PARITY error: XOR of bits[9:1] = 1.
- VALID: none of the above.

State machine (updi_rx_state_t):
- WAIT_SYNCH (reset state):
  - VALID 0x55 -> ACTIVE, pulse synch_seen. The SYNCH byte is consumed, not pushed.
  - Any other VALID, PARITY or FRAME -> discarded; stay in WAIT_SYNCH; no error pulse.
- ACTIVE:
  - VALID -> push byte_data.
  - FIFO full with no simultaneous pop -> drop the byte, pulse err_overrun, go to ERROR.
  - PARITY or FRAME -> pulse the matching error, go to ERROR.
- ERROR: all non-BREAK frames are silently discarded.
- BREAK in any state -> flush the FIFO, pulse break_det, go to WAIT_SYNCH.
- Entry to ERROR flushes the FIFO.

Boundary rules:
- Push when full with a simultaneous pop: the push is accepted and count is unchanged.
- Flush coincident with a pop: the flush wins and byte_valid is 0 next cycle.
- frm_valid is low for at least 11 cycles between frames; back-to-back strobes need not be handled.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - State WAIT_SYNCH; FIFO empty.
  - byte_valid = 0, byte_data = 0, link_active = 0.
  - All pulse outputs 0; err_cnt = 0.
- Frame in at edge N -> classification, state change, FIFO write and pulses are all registered at edge N.
- Effects are visible in the cycle after N:
  - byte_valid rises one cycle after the strobe when the FIFO was empty.
  - link_active changes in the same cycle as the pulses.
- Pops are single-cycle; the next head byte is on byte_data in the following cycle.
- rst asserted mid-operation overrides every input at that edge: FIFO is emptied, state returns to WAIT_SYNCH, and no pulse is generated.

## Configuration
- UPDI_RX_ERRCNT_EN defined:
  - err_cnt increments by 1 on each err_parity, err_frame or err_overrun event.
  - It saturates at all-ones and clears only on rst.
- UPDI_RX_ERRCNT_EN undefined:
  - No counter register exists; err_cnt is tied to 0.
  - Error pulses are unaffected.

## Structure
- Package updi_rx_pkg holds:
  - updi_rx_state_t enum (WAIT_SYNCH, ACTIVE, ERROR).
  - Localparams UPDI_SYNCH_CHAR = 8'h55 and UPDI_BREAK_FRAME = 12'h000.
  - Field positions: START_BIT = 0, DATA_LSB = 1, DATA_MSB = 8, PARITY_BIT = 9, STOP_LSB = 10, STOP_MSB = 11.
- Sub-module updi_rx_fifo: synchronous FIFO with push, pop, flush, full and empty signals, parameterised by FIFO_DEPTH. The deframer holds the classifier, the FSM and the counter.

## Test plan
- Reset, then frm_data = 12'hCAA (0x55) -> synch_seen pulse, link_active = 1, byte_valid stays 0.
- After SYNCH, send 12'hE02 then 12'hD4A with byte_ready = 1 -> bytes 0x01 then 0xA5 appear, each one cycle after its strobe; no error pulses.
- Active link, send 12'hC02 (0x01 with bad parity) -> err_parity pulse, link_active = 0, FIFO flushed. A following 12'hCAA is ignored; 12'h000 -> break_det pulse, state WAIT_SYNCH.
- Active link with byte_ready = 0, push FIFO_DEPTH + 1 bytes -> the extra byte is dropped, err_overrun pulse, state ERROR. Repeat with byte_ready = 1 on the last strobe -> accepted, no error.
- Frame 12'h4AA (bad stop) while active -> err_frame pulse; with UPDI_RX_ERRCNT_EN, err_cnt = 1. Force 2^ERRCNT_W + 3 errors -> err_cnt saturates at all-ones.
- Assert rst while the FIFO holds 3 bytes -> byte_valid = 0 and link_active = 0 next cycle, no pulses; err_cnt = 0.
